// File: rtl/slavefifo2b_pkg.sv
// Shared encodings for the FX3 slave-FIFO mode controller: request modes,
// controller states and source count.
package slavefifo2b_pkg;

    localparam int NUM_SRC = 4;

    typedef enum logic [2:0] {
        MODE_NONE      = 3'd0,
        MODE_STREAM_IN = 3'd1,
        MODE_LOOPBACK  = 3'd2,
        MODE_PARTIAL   = 3'd3,
        MODE_ZLP       = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_QUIESCE = 2'd2,
        ST_GUARD   = 2'd3
    } state_t;

    // Requests above MODE_ZLP carry no meaning and collapse to "no source".
    function automatic logic [2:0] sanitize_mode(input logic [2:0] req);
        return (req > MODE_ZLP) ? MODE_NONE : req;
    endfunction

    function automatic logic [NUM_SRC-1:0] mode_onehot(input logic [2:0] m);
        logic [NUM_SRC-1:0] oh;
        oh = '0;
        case (m)
            MODE_STREAM_IN: oh = 4'b0001;
            MODE_LOOPBACK:  oh = 4'b0010;
            MODE_PARTIAL:   oh = 4'b0100;
            MODE_ZLP:       oh = 4'b1000;
            default:        oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/slavefifo2b_bus_mux.sv
// Combinational write-bus select: drives the granted source onto the FX3 bus,
// or holds the bus idle (strobes high, data zero) when no source is live.
module slavefifo2b_bus_mux
    import slavefifo2b_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                      bus_live,
    input  logic [1:0]                src_idx,
    input  logic [NUM_SRC-1:0]        src_slwr_n,
    input  logic [NUM_SRC-1:0]        src_pktend_n,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      slwr_,
    output logic                      pktend_,
    output logic [DATA_W-1:0]         data_out
);

    always_comb begin
        slwr_    = 1'b1;
        pktend_  = 1'b1;
        data_out = '0;
        if (bus_live) begin
            slwr_    = src_slwr_n[src_idx];
            pktend_  = src_pktend_n[src_idx];
            data_out = src_data[int'(src_idx) * DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/slavefifo2b_mode_ctrl.sv
// FX3 slave-FIFO write-bus owner: grants one of four traffic generators and
// sequences mode changes as quiesce -> idle guard gap -> enable new source.
module slavefifo2b_mode_ctrl
    import slavefifo2b_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int GUARD_CYC   = 8,
    parameter int QUIESCE_MAX = 1023
) (
    input  logic                      clk_100,
    input  logic                      reset_,
    input  logic [2:0]                mode_req,
    input  logic [NUM_SRC-1:0]        src_busy,
    input  logic [NUM_SRC-1:0]        src_slwr_n,
    input  logic [NUM_SRC-1:0]        src_pktend_n,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        mode_sel,
    output logic                      slwr_,
    output logic                      pktend_,
    output logic [DATA_W-1:0]         data_out,
    output logic [2:0]                cur_mode,
    output logic                      switch_done,
    output logic                      err_invalid,
    output logic                      err_timeout,
    output logic [1:0]                fsm_state
);

    localparam int QW = $clog2(QUIESCE_MAX + 1);

    state_t         state;
    logic [2:0]     tgt;
    logic [7:0]     guard_cnt;
    logic [QW-1:0]  q_cnt;
    logic [2:0]     req_mode;
    logic           req_invalid;
    logic [1:0]     cur_idx;
    logic           cur_busy;
    logic           bus_live;

    assign req_invalid = (mode_req > MODE_ZLP);
    assign req_mode    = sanitize_mode(mode_req);
    assign cur_idx     = 2'(cur_mode - 3'd1);
    assign cur_busy    = src_busy[cur_idx];
    assign bus_live    = (state == ST_ACTIVE) || (state == ST_QUIESCE);
    assign fsm_state   = state;

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            state       <= ST_IDLE;
            tgt         <= MODE_NONE;
            cur_mode    <= MODE_NONE;
            mode_sel    <= '0;
            guard_cnt   <= '0;
            q_cnt       <= '0;
            switch_done <= 1'b0;
            err_invalid <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            switch_done <= 1'b0;
            // Requests are only looked at while no switch is in flight.
            if (req_invalid && (state == ST_IDLE || state == ST_ACTIVE))
                err_invalid <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (req_mode != MODE_NONE) begin
                        tgt       <= req_mode;
                        guard_cnt <= '0;
                        state     <= ST_GUARD;
                    end
                end

                ST_ACTIVE: begin
                    if (req_mode != cur_mode) begin
                        tgt   <= req_mode;
                        q_cnt <= '0;
                        state <= ST_QUIESCE;
                    end
                end

                ST_QUIESCE: begin
                    if (!cur_busy) begin
                        mode_sel  <= '0;
                        guard_cnt <= '0;
                        state     <= ST_GUARD;
                    end else if (q_cnt == QW'(QUIESCE_MAX - 1)) begin
                        // Source never finished its packet: force the switch.
                        err_timeout <= 1'b1;
                        mode_sel    <= '0;
                        guard_cnt   <= '0;
                        state       <= ST_GUARD;
                    end else begin
                        q_cnt <= q_cnt + 1'b1;
                    end
                end

                ST_GUARD: begin
                    if (guard_cnt == 8'(GUARD_CYC - 1)) begin
                        cur_mode    <= tgt;
                        mode_sel    <= mode_onehot(tgt);
                        switch_done <= 1'b1;
                        state       <= (tgt != MODE_NONE) ? ST_ACTIVE : ST_IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    slavefifo2b_bus_mux #(
        .DATA_W(DATA_W)
    ) u_bus_mux (
        .bus_live     (bus_live),
        .src_idx      (cur_idx),
        .src_slwr_n   (src_slwr_n),
        .src_pktend_n (src_pktend_n),
        .src_data     (src_data),
        .slwr_        (slwr_),
        .pktend_      (pktend_),
        .data_out     (data_out)
    );

endmodule

// File: tb/tb_slavefifo2b_mode_ctrl.sv
// Bench for slavefifo2b_mode_ctrl: randomized mode requests and source traffic
// against a timeline model of quiesce/guard switching.
`timescale 1ns/1ps
module tb_slavefifo2b_mode_ctrl;

    localparam int DATA_W      = 32;
    localparam int GUARD_CYC   = 8;
    localparam int QUIESCE_MAX = 1023;
    localparam int EW          = 37;

    logic                clk_100 = 1'b0;
    logic                reset_  = 1'b0;
    logic [2:0]          mode_req = 3'd0;
    logic [3:0]          src_busy = 4'd0;
    logic [3:0]          src_slwr_n = 4'hf;
    logic [3:0]          src_pktend_n = 4'hf;
    logic [4*DATA_W-1:0] src_data = '0;
    logic [3:0]          mode_sel;
    logic                slwr_;
    logic                pktend_;
    logic [DATA_W-1:0]   data_out;
    logic [2:0]          cur_mode;
    logic                switch_done;
    logic                err_invalid;
    logic                err_timeout;
    logic [1:0]          fsm_state;

    slavefifo2b_mode_ctrl #(
        .DATA_W(DATA_W), .GUARD_CYC(GUARD_CYC), .QUIESCE_MAX(QUIESCE_MAX)
    ) dut (
        .clk_100      (clk_100),
        .reset_       (reset_),
        .mode_req     (mode_req),
        .src_busy     (src_busy),
        .src_slwr_n   (src_slwr_n),
        .src_pktend_n (src_pktend_n),
        .src_data     (src_data),
        .mode_sel     (mode_sel),
        .slwr_        (slwr_),
        .pktend_      (pktend_),
        .data_out     (data_out),
        .cur_mode     (cur_mode),
        .switch_done  (switch_done),
        .err_invalid  (err_invalid),
        .err_timeout  (err_timeout),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_100 = ~clk_100;

    int unsigned cyc = 0;
    always @(posedge clk_100) cyc <= cyc + 1;

    // ---------------- model state / scoreboard ----------------
    int          asserts = 0;
    int          fails   = 0;
    logic [EW-1:0] exp_q[$];   // {switch cycle, mode, err_timeout, err_invalid}
    int          m_mode    = 0;
    bit          m_err_inv = 0;
    bit          m_err_to  = 0;
    bit          exp_live  = 0;
    int          exp_src   = 1;
    logic [3:0]  exp_sel   = 4'd0;
    logic [3:0]  busy_mask = 4'd0;
    bit          busy_on   = 0;
    bit          mon_en    = 0;

    function automatic logic [3:0] onehot(input int m);
        return (m == 0) ? 4'd0 : (4'b0001 << (m - 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk_100);
        #1;
        src_slwr_n   = 4'($urandom);
        src_pktend_n = 4'($urandom);
        for (int i = 0; i < 4; i++) src_data[i*DATA_W +: DATA_W] = $urandom;
        src_busy = (4'($urandom) & ~busy_mask) | (busy_on ? busy_mask : 4'd0);
    endtask

    // Issue request r; the outgoing source stays busy for b cycles. Optionally
    // change mode_req to chg_val after chg_at cycles (must be ignored).
    task automatic do_req(input logic [2:0] r, input int b, input int chg_at, input logic [2:0] chg_val);
        int tgt, from, clamp, total;
        tgt = (r > 3'd4) ? 0 : int'(r);
        if (r > 3'd4) m_err_inv = 1;
        mode_req = r;
        if (tgt == m_mode) begin
            repeat (4) step();
            chk("noop_cur_mode", 32'(cur_mode), 32'(m_mode));
            chk("noop_err_invalid", 32'(err_invalid), 32'(m_err_inv));
            return;
        end
        from  = m_mode;
        clamp = (b < 1) ? 1 : ((b > QUIESCE_MAX) ? QUIESCE_MAX : b);
        if (from != 0 && b > QUIESCE_MAX) m_err_to = 1;
        total = ((from != 0) ? 1 + clamp : 1) + GUARD_CYC;
        exp_q.push_back({32'(cyc + total), 3'(tgt), m_err_to, m_err_inv});
        if (from != 0) begin
            busy_mask = onehot(from);
            busy_on   = (b > 0);
        end
        for (int s = 1; s <= total; s++) begin
            step();
            if (s == b) begin
                busy_on  = 0;
                src_busy = src_busy & ~busy_mask;
            end
            if (s == chg_at) mode_req = chg_val;
            if (from != 0 && s == 1 + clamp) begin
                exp_live = 0;
                exp_sel  = 4'd0;
            end
        end
        busy_on   = 0;
        busy_mask = 4'd0;
        m_mode    = tgt;
        exp_live  = (tgt != 0);
        exp_src   = (tgt != 0) ? tgt : 1;
        exp_sel   = onehot(tgt);
        @(negedge clk_100);
        #1;
        chk("switch_seen", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_100) begin : monitor
        logic [EW-1:0] e;
        if (mon_en && reset_) begin
            chk("mode_sel", 32'(mode_sel), 32'(exp_sel));
            if (exp_live) begin
                chk("slwr_live", 32'(slwr_), 32'(src_slwr_n[exp_src-1]));
                chk("pktend_live", 32'(pktend_), 32'(src_pktend_n[exp_src-1]));
                chk("data_live", data_out, src_data[(exp_src-1)*DATA_W +: DATA_W]);
            end else begin
                chk("slwr_idle", 32'(slwr_), 32'd1);
                chk("pktend_idle", 32'(pktend_), 32'd1);
                chk("data_idle", data_out, 32'd0);
            end
            if (switch_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_switch", 32'(switch_done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("switch_cycle", cyc, e[36:5]);
                    chk("switch_cur_mode", 32'(cur_mode), 32'(e[4:2]));
                    chk("switch_mode_sel", 32'(mode_sel), 32'(onehot(int'(e[4:2]))));
                    chk("switch_err_timeout", 32'(err_timeout), 32'(e[1]));
                    chk("switch_err_invalid", 32'(err_invalid), 32'(e[0]));
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got cycle %0d expected finish", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) step();
        chk("rst_mode_sel", 32'(mode_sel), 32'd0);
        chk("rst_slwr", 32'(slwr_), 32'd1);
        chk("rst_pktend", 32'(pktend_), 32'd1);
        chk("rst_data", data_out, 32'd0);
        chk("rst_cur_mode", 32'(cur_mode), 32'd0);
        chk("rst_switch_done", 32'(switch_done), 32'd0);
        chk("rst_err_invalid", 32'(err_invalid), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        @(negedge clk_100);
        reset_ = 1'b1;
        mon_en = 1;

        // Grant from idle, then live partial traffic.
        do_req(3'd3, 0, 0, 3'd0);
        repeat (5) step();

        // Busy source held 20 cycles before the switch.
        do_req(3'd1, 2, 0, 3'd0);
        do_req(3'd2, 20, 0, 3'd0);

        // Stuck-busy source forces a timeout.
        do_req(3'd4, 5, 0, 3'd0);
        do_req(3'd1, 1100, 0, 3'd0);

        // Invalid request from idle, then a valid one.
        do_req(3'd0, 3, 0, 3'd0);
        do_req(3'd6, 0, 0, 3'd0);
        chk("invalid_stays_idle", 32'(fsm_state), 32'd0);
        do_req(3'd2, 0, 0, 3'd0);

        // Request change during guard is ignored; re-evaluated once active.
        do_req(3'd0, 2, 0, 3'd0);
        do_req(3'd3, 0, 4, 3'd1);
        do_req(3'd1, 7, 0, 3'd0);

        // Randomized mode traffic.
        for (int n = 0; n < 30; n++) begin
            do_req(3'($urandom_range(0, 7)), int'($urandom_range(0, 25)), 0, 3'd0);
            repeat ($urandom_range(0, 3)) step();
        end

        // Asynchronous reset while mode 1 is active.
        do_req(3'd1, 3, 0, 3'd0);
        @(posedge clk_100);
        #3;
        reset_ = 1'b0;
        #1;
        chk("async_rst_mode_sel", 32'(mode_sel), 32'd0);
        chk("async_rst_slwr", 32'(slwr_), 32'd1);
        chk("async_rst_cur_mode", 32'(cur_mode), 32'd0);
        chk("async_rst_err_invalid", 32'(err_invalid), 32'd0);
        chk("async_rst_err_timeout", 32'(err_timeout), 32'd0);
        m_mode    = 0;
        m_err_inv = 0;
        m_err_to  = 0;
        exp_live  = 0;
        exp_src   = 1;
        exp_sel   = 4'd0;
        mode_req  = 3'd0;
        @(negedge clk_100);
        reset_ = 1'b1;
        do_req(3'd2, 0, 0, 3'd0);
        repeat (3) step();

        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/slavefifo2b_mode_ctrl.md
Name: slavefifo2b_mode_ctrl

Overview:
- Mode controller owning the FX3 slave-FIFO write bus (slwr_, pktend_, 32-bit data) on clk_100.
- Four traffic generators share the bus: stream-IN, loopback, partial and ZLP. Each exposes active-low slwr/pktend, 32-bit data, and a busy flag.
- Selects exactly one generator, asserts that generator's mode-selected enable, and muxes its outputs onto the bus.
- Sequences glitch-free mode changes: the old source is quiesced and a guard gap is inserted before the new source is enabled.

Parameters:
- DATA_W, 32, bus data width.
- GUARD_CYC, 8, idle bus cycles between deselecting one source and selecting the next (1..255).
- QUIESCE_MAX, 1023, maximum cycles to wait for the old source's busy flag to drop before forcing the switch.

Ports:
- clk_100  in  1  system clock; all logic rising-edge.
- reset_  in  1  asynchronous active-low reset.
- mode_req  in  3  requested mode, level-sampled: 0=none, 1=stream_in, 2=loopback, 3=partial, 4=zlp, 5..7 invalid.
- src_busy  in  4  per-source busy, bit i = mode i+1; high while the source is mid-packet.
- src_slwr_n  in  4  per-source active-low write strobe.
- src_pktend_n  in  4  per-source active-low packet end.
- src_data  in  4*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W].
- mode_sel  out  4  one-hot mode-selected enables to the sources.
- slwr_  out  1  muxed write strobe to FX3.
- pktend_  out  1  muxed packet end to FX3.
- data_out  out  DATA_W  muxed data.
- cur_mode  out  3  currently granted mode (0 when none).
- switch_done  out  1  one-cycle pulse when a new mode becomes active or IDLE is reached after a switch.
- err_invalid  out  1  sticky; set on a 5..7 request.
- err_timeout  out  1  sticky; set on a forced switch.

Behaviour:
Reset values:
- State IDLE, cur_mode=0, mode_sel=0, slwr_=1, pktend_=1, data_out=0, switch_done=0, both errors 0.
- Reset asserted mid-operation drops mode_sel at once (asynchronous).

States:
- IDLE: mode_sel=0. When mode_req is 1..4, latch tgt=mode_req and go to GUARD with guard counter 0.
- ACTIVE: mode_sel[cur_mode-1]=1. When mode_req differs from cur_mode, latch tgt and go to QUIESCE.
- QUIESCE: mode_sel stays asserted so the source can finish its packet; count cycles.
  - Exit to GUARD when src_busy[cur_mode-1]=0.
  - If the count reaches QUIESCE_MAX first, set err_timeout and go to GUARD.
- GUARD: mode_sel=0 and the bus is forced idle for GUARD_CYC cycles.
  - Then cur_mode<=tgt and switch_done=1.
  - Next state is ACTIVE if tgt≠0, otherwise IDLE.

Request handling:
- An invalid request (5..7) is treated as 0 (none) and sets err_invalid.
- mode_req changes during QUIESCE or GUARD are ignored; tgt is fixed once latched. After the switch completes, ACTIVE re-evaluates mode_req on the next cycle.
- A request equal to cur_mode takes no action.

Bus mux (combinational, zero added latency):
- In ACTIVE and QUIESCE: slwr_, pktend_ and data_out are taken from source cur_mode-1.
- In IDLE and GUARD: slwr_=1, pktend_=1, data_out=0.
- Stray strobes from unselected sources are never propagated.

Counters:
- Guard counter is 8 bits; quiesce counter is clog2(QUIESCE_MAX+1) bits.
- Both clear on every state entry. No wrap-around is possible.

Decomposition:
- Shared package slavefifo2b_pkg holds:
  - mode encodings MODE_NONE, MODE_STREAM_IN, MODE_LOOPBACK, MODE_PARTIAL, MODE_ZLP;
  - state encodings ST_IDLE, ST_ACTIVE, ST_QUIESCE, ST_GUARD;
  - the NUM_SRC=4 constant.
- One natural sub-module, slavefifo2b_bus_mux: purely combinational source select plus idle forcing. The FSM and counters stay in the top module.

Test Plan:
1. Reset then mode_req=3 → GUARD for 8 cycles with slwr_=1 and mode_sel=0; then mode_sel=4'b0100, cur_mode=3, one switch_done pulse. Partial source strobes then appear on slwr_/data_out the same cycle.
2. Active mode 1, change mode_req to 2 while src_busy[0]=1 for 20 cycles → mode_sel[0] held 20 cycles, then 8 idle cycles, then mode_sel=4'b0010.
3. Active mode 4, src_busy[3] stuck high, request 1 → after 1023 cycles err_timeout=1, guard, then mode 1 active.
4. Request 6 from IDLE → err_invalid=1 and state stays IDLE. A later request of 2 still activates mode 2; err_invalid remains 1.
5. During GUARD toward mode 3, mode_req changes to 1 → mode 3 is granted first. The next cycle ACTIVE sees mode_req=1 and starts a new switch.
6. Drive reset_ low while ACTIVE with mode_sel=4'b0001 → mode_sel=0, slwr_=1, cur_mode=0 immediately (asynchronous).
